lcd_frame_writer: RTL and testbench

//  Continuous-refresh HD44780 write engine: consumes the LINES x CHARS character grid built by the

---
 rtl/lcd_frame_writer.sv | 149 ++++++++++++++
 tb/tb_lcd_frame_writer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_writer.sv
// Purpose: continuously refreshes an HD44780 from a LINES x CHARS grid (set-address then data writes).
// Latency: one transaction every SETUP_CYC+E_HIGH_CYC+EXEC_CYC cycles; first bus value 1 cycle after initilized.
// Backpressure: none; initilized low parks the engine in IDLE after the transaction in flight finishes.
module lcd_frame_writer #(
    parameter int LINES = 4,
    parameter int CHARS = 20,
    parameter logic [0:LINES-1][6:0] LINE_STARTS = {7'h00, 7'h40, 7'h14, 7'h54},
    parameter int SETUP_CYC  = 2,
    parameter int E_HIGH_CYC = 25,
    parameter int EXEC_CYC   = 2500
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 initilized,
    input  logic [0:LINES-1][0:CHARS-1][7:0]     display_chars,
    output logic                                 RS,
    output logic                                 RW,
    output logic                                 E,
    output logic [7:0]                           DATA,
    output logic                                 frame_done
);

    localparam int MAX_AB  = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
    localparam int MAX_CYC = (MAX_AB > EXEC_CYC) ? MAX_AB : EXEC_CYC;
    localparam int CNT_W   = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;
    localparam int LINE_W  = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int COL_W   = (CHARS > 1) ? $clog2(CHARS) : 1;

    localparam logic [CNT_W-1:0]  SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0]  PULSE_LD  = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0]  EXEC_LD   = CNT_W'(EXEC_CYC - 1);
    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINES - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(CHARS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, CHAR} state_t;
    typedef enum logic [1:0] {SETUP, PULSE, EXEC} phase_t;

    state_t              state_q, state_d;
    phase_t              phase_q, phase_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   line_q, line_d, line_nx;
    logic [COL_W-1:0]    col_q, col_d, col_nx;
    logic                rs_d, e_d, done_d;
    logic [7:0]          data_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            phase_q    <= SETUP;
            cnt_q      <= '0;
            line_q     <= '0;
            col_q      <= '0;
            RS         <= 1'b0;
            RW         <= 1'b0;
            E          <= 1'b0;
            DATA       <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            line_q     <= line_d;
            col_q      <= col_d;
            RS         <= rs_d;
            RW         <= 1'b0;
            E          <= e_d;
            DATA       <= data_d;
            frame_done <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        col_d   = col_q;
        line_nx = line_q;
        col_nx  = col_q;
        rs_d    = RS;
        e_d     = E;
        data_d  = DATA;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (initilized) begin
                    state_d = ADDR;
                    phase_d = SETUP;
                    cnt_d   = SETUP_LD;
                    line_d  = '0;
                    col_d   = '0;
                    rs_d    = 1'b0;
                    e_d     = 1'b0;
                    data_d  = {1'b1, LINE_STARTS[0]};
                end
            end
            default: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    case (phase_q)
                        SETUP: begin
                            phase_d = PULSE;
                            cnt_d   = PULSE_LD;
                            e_d     = 1'b1;
                        end
                        PULSE: begin
                            phase_d = EXEC;
                            cnt_d   = EXEC_LD;
                            e_d     = 1'b0;
                        end
                        default: begin
                            // Transaction complete: the only point where init loss is honoured.
                            phase_d = SETUP;
                            cnt_d   = SETUP_LD;
                            if (!initilized) begin
                                state_d = IDLE;
                                line_d  = '0;
                                col_d   = '0;
                                e_d     = 1'b0;
                            end else if (state_q == ADDR) begin
                                state_d = CHAR;
                                rs_d    = 1'b1;
                                data_d  = display_chars[line_q][col_q];
                            end else if (col_q == LAST_COL) begin
                                state_d = ADDR;
                                col_d   = '0;
                                rs_d    = 1'b0;
                                if (line_q == LAST_LINE) begin
                                    line_nx = '0;
                                    done_d  = 1'b1;
                                end else begin
                                    line_nx = line_q + 1'b1;
                                end
                                line_d = line_nx;
                                data_d = {1'b1, LINE_STARTS[line_nx]};
                            end else begin
                                col_nx = col_q + 1'b1;
                                col_d  = col_nx;
                                data_d = display_chars[line_q][col_nx];
                            end
                        end
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Bench for lcd_frame_writer with short bus timing (T = 6 cycles); expected bus writes are queued
// from a grid model and compared against writes captured on each E strobe.
module tb_lcd_frame_writer;

    logic                     clk;
    logic                     reset;
    logic                     initilized;
    logic [0:3][0:19][7:0]    grid;
    logic                     RS, RW, E, frame_done;
    logic [7:0]               DATA;

    lcd_frame_writer #(
        .LINES(4), .CHARS(20),
        .SETUP_CYC(1), .E_HIGH_CYC(2), .EXEC_CYC(3)
    ) dut (
        .clk(clk), .reset(reset), .initilized(initilized), .display_chars(grid),
        .RS(RS), .RW(RW), .E(E), .DATA(DATA), .frame_done(frame_done)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         hi_len;
        int         setup_len;
        int         rise_cyc;
    } txn_t;

    txn_t       obs_q[$];
    logic [8:0] exp_q[$];
    txn_t       cur;
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         rise_cnt = 0;
    int         fd_count = 0;
    int         fd_rise = -1;
    int         chg_cyc = 0;
    logic       prev_e = 1'b0;
    logic [8:0] prev_bus = '0;
    logic [7:0] addr_of [4] = '{8'h80, 8'hC0, 8'h94, 8'hD4};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Bus monitor: one record per E strobe, captured at its falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            obs_q.delete();
            rise_cnt = 0;
            fd_count = 0;
            fd_rise  = -1;
            prev_e   = 1'b0;
            prev_bus = '0;
        end else begin
            if ({RS, DATA} !== prev_bus) chg_cyc = cyc;
            prev_bus = {RS, DATA};
            if (E && !prev_e) begin
                rise_cnt++;
                cur.rise_cyc  = cyc;
                cur.setup_len = cyc - chg_cyc;
            end
            if (!E && prev_e) begin
                cur.hi_len = cyc - cur.rise_cyc;
                cur.rs     = RS;
                cur.data   = DATA;
                obs_q.push_back(cur);
            end
            if (frame_done) begin
                fd_count++;
                fd_rise = rise_cnt;
            end
            prev_e = E;
        end
    end

    function automatic logic [8:0] exp_txn(int idx);
        int ln = idx / 21;
        int k  = idx % 21;
        if (k == 0) return {1'b0, addr_of[ln]};
        return {1'b1, grid[ln][k-1]};
    endfunction

    task automatic wait_obs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (obs_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        int rises;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (RS !== 1'b0) begin miscompares++; $display("FAIL reset_rs got %b want 0", RS); end
        vectors++; if (RW !== 1'b0) begin miscompares++; $display("FAIL reset_rw got %b want 0", RW); end
        vectors++; if (E !== 1'b0) begin miscompares++; $display("FAIL reset_e got %b want 0", E); end
        vectors++; if (DATA !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", DATA); end
        vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_fd got %b want 0", frame_done); end
        initilized = 1'b0;
        reset = 1'b1;
        rises = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (E !== 1'b0) rises++;
        end
        vectors++; if (rises !== 0) begin miscompares++; $display("FAIL idle_e high for %0d cycles, want 0", rises); end
    endtask

    task automatic test_first_txn;
        bit ok;
        txn_t t;
        logic [8:0] ex;
        int prev_rise;
        initilized = 1'b1;
        for (int i = 0; i < 21; i++) exp_q.push_back(exp_txn(i));
        prev_rise = 0;
        for (int i = 0; i < 21; i++) begin
            wait_obs(ok);
            if (!ok) begin vectors++; miscompares++; $display("FAIL first_txn timeout at %0d", i); break; end
            t = obs_q.pop_front();
            ex = exp_q.pop_front();
            vectors++; if ({t.rs, t.data} !== ex) begin miscompares++;
                $display("FAIL first_txn[%0d] got rs=%b data=%h want rs=%b data=%h", i, t.rs, t.data, ex[8], ex[7:0]); end
            vectors++; if (t.hi_len !== 2) begin miscompares++; $display("FAIL e_high[%0d] got %0d want 2", i, t.hi_len); end
            vectors++; if (t.setup_len !== 1) begin miscompares++; $display("FAIL setup[%0d] got %0d want 1", i, t.setup_len); end
            if (i > 0) begin
                vectors++; if (t.rise_cyc - prev_rise !== 6) begin miscompares++;
                    $display("FAIL spacing[%0d] got %0d want 6", i, t.rise_cyc - prev_rise); end
            end
            prev_rise = t.rise_cyc;
        end
    endtask

    task automatic test_full_frame;
        bit ok;
        txn_t t;
        logic [8:0] ex;
        for (int i = 21; i < 84; i++) exp_q.push_back(exp_txn(i));
        for (int i = 21; i < 84; i++) begin
            wait_obs(ok);
            if (!ok) begin vectors++; miscompares++; $display("FAIL frame timeout at %0d", i); break; end
            t = obs_q.pop_front();
            ex = exp_q.pop_front();
            vectors++; if ({t.rs, t.data} !== ex) begin miscompares++;
                $display("FAIL frame[%0d] got rs=%b data=%h want rs=%b data=%h", i, t.rs, t.data, ex[8], ex[7:0]); end
        end
    endtask

    task automatic test_frame_done;
        bit ok;
        txn_t t;
        logic [8:0] ex;
        exp_q.push_back(exp_txn(0));
        wait_obs(ok);
        if (!ok) begin
            vectors++; miscompares++; $display("FAIL wrap timeout");
        end else begin
            t = obs_q.pop_front();
            ex = exp_q.pop_front();
            vectors++; if ({t.rs, t.data} !== ex) begin miscompares++;
                $display("FAIL wrap_addr got rs=%b data=%h want rs=%b data=%h", t.rs, t.data, ex[8], ex[7:0]); end
        end
        vectors++; if (fd_count !== 1) begin miscompares++; $display("FAIL fd_count got %0d want 1", fd_count); end
        vectors++; if (fd_rise !== 84) begin miscompares++; $display("FAIL fd_after_edge got %0d want 84", fd_rise); end
    endtask

    task automatic test_snapshot;
        bit ok;
        txn_t t;
        logic [8:0] ex;
        int bad, n;
        for (int i = 1; i < 28; i++) exp_q.push_back(exp_txn(i));
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (rise_cnt == 112 && E === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin vectors++; miscompares++; $display("FAIL snapshot pulse not reached"); end
        grid[1][5] = 8'h79;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (DATA !== 8'h78 || RS !== 1'b1) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL snapshot_hold changed in %0d cycles, want 0 (data=%h)", bad, DATA); end
        for (int i = 28; i < 84; i++) exp_q.push_back(exp_txn(i));
        for (int i = 0; i < 28; i++) exp_q.push_back(exp_txn(i));
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            wait_obs(ok);
            if (!ok) begin vectors++; miscompares++; $display("FAIL snapshot timeout at %0d", i); break; end
            t = obs_q.pop_front();
            ex = exp_q.pop_front();
            vectors++; if ({t.rs, t.data} !== ex) begin miscompares++;
                $display("FAIL snapshot[%0d] got rs=%b data=%h want rs=%b data=%h", i, t.rs, t.data, ex[8], ex[7:0]); end
        end
    endtask

    task automatic test_abort;
        bit ok;
        txn_t t;
        logic [8:0] ex;
        int base, fd_before, bad;
        base = rise_cnt;
        fd_before = fd_count;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rise_cnt > base) begin ok = 1'b1; break; end
        end
        if (!ok) begin vectors++; miscompares++; $display("FAIL abort pulse not reached"); end
        initilized = 1'b0;
        wait_obs(ok);
        if (!ok) begin
            vectors++; miscompares++; $display("FAIL abort txn timeout");
        end else begin
            t = obs_q.pop_front();
            vectors++; if (t.hi_len !== 2) begin miscompares++; $display("FAIL abort_e_high got %0d want 2", t.hi_len); end
            vectors++; if ({t.rs, t.data} !== {1'b1, grid[1][6]}) begin miscompares++;
                $display("FAIL abort_txn got rs=%b data=%h want rs=1 data=%h", t.rs, t.data, grid[1][6]); end
        end
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (E !== 1'b0) bad++;
        end
        vectors++; if (bad !== 0) begin miscompares++; $display("FAIL abort_idle_e high %0d cycles want 0", bad); end
        vectors++; if (rise_cnt !== base + 1) begin miscompares++; $display("FAIL abort_rises got %0d want %0d", rise_cnt, base + 1); end
        vectors++; if (fd_count !== fd_before) begin miscompares++; $display("FAIL abort_fd got %0d want %0d", fd_count, fd_before); end
        initilized = 1'b1;
        exp_q.push_back(exp_txn(0));
        exp_q.push_back(exp_txn(1));
        for (int i = 0; i < 2; i++) begin
            wait_obs(ok);
            if (!ok) begin vectors++; miscompares++; $display("FAIL resume timeout at %0d", i); break; end
            t = obs_q.pop_front();
            ex = exp_q.pop_front();
            vectors++; if ({t.rs, t.data} !== ex) begin miscompares++;
                $display("FAIL resume[%0d] got rs=%b data=%h want rs=%b data=%h", i, t.rs, t.data, ex[8], ex[7:0]); end
        end
    endtask

    task automatic test_reset_mid_pulse;
        bit ok;
        txn_t t;
        logic [8:0] ex;
        int base;
        base = rise_cnt;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rise_cnt > base && E === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin vectors++; miscompares++; $display("FAIL rst_pulse not reached"); end
        reset = 1'b0;
        #1;
        vectors++; if (E !== 1'b0) begin miscompares++; $display("FAIL rst_async_e got %b want 0", E); end
        vectors++; if (DATA !== 8'h00) begin miscompares++; $display("FAIL rst_async_data got %h want 00", DATA); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(exp_txn(i));
        for (int i = 0; i < 3; i++) begin
            wait_obs(ok);
            if (!ok) begin vectors++; miscompares++; $display("FAIL restart timeout at %0d", i); break; end
            t = obs_q.pop_front();
            ex = exp_q.pop_front();
            vectors++; if ({t.rs, t.data} !== ex) begin miscompares++;
                $display("FAIL restart[%0d] got rs=%b data=%h want rs=%b data=%h", i, t.rs, t.data, ex[8], ex[7:0]); end
        end
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        initilized = 1'b1;
        for (int c = 0; c < 20; c++) begin
            grid[0][c] = 8'h41 + 8'(c);
            grid[1][c] = 8'h78;
            grid[2][c] = 8'h61 + 8'(c);
            grid[3][c] = 8'h30 + 8'(c % 10);
        end
        test_reset;
        test_first_txn;
        test_full_frame;
        test_frame_done;
        test_snapshot;
        test_abort;
        test_reset_mid_pulse;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
